p2s_tx_arbiter: RTL and testbench

- Arbitrated serial-transmit controller.
- Shares one parallel-to-serial shifter between two requesters, each presenting a DATA_W-bit word.
- Grants requesters round-robin, captures the winner's word, and shifts it out LSB-first followed by an even-parity bit.
- Sits between the parallel datapath (ALU/DFF stages) and the serial link, and sequences the parity and parallel-to-serial functions as one frame.

---
 rtl/p2s_tx_arbiter_if.sv | 28 ++
 rtl/p2s_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_p2s_tx_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p2s_tx_arbiter_if.sv
// Request/grant and serial-link bundle for the arbitrated serial transmitter.
// The requesters (master side) drive requests and words; the transmitter
// (slave side) returns grants and the serial frame.
interface p2s_tx_arbiter_if #(
  parameter int DATA_W = 4
);
  logic              req0;
  logic [DATA_W-1:0] data0;
  logic              req1;
  logic [DATA_W-1:0] data1;
  logic              gnt0;
  logic              gnt1;
  logic              ser_out;
  logic              ser_valid;
  logic              frame_sel;
  logic              done;
  logic              busy;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, ser_out, ser_valid, frame_sel, done, busy
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, ser_out, ser_valid, frame_sel, done, busy
  );
endinterface

// File: rtl/p2s_tx_arbiter.sv
// Arbitrated serial transmitter: two requesters share one parallel-to-serial
// shifter. Round-robin grant, LSB-first data bits, then one even-parity bit.
// Every output is a flop fed from the next-state logic, so the first data bit
// and the grant pulse appear in the cycle right after the accept edge.
module p2s_tx_arbiter #(
  parameter int DATA_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  p2s_tx_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shreg_reg, shreg_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              parity_reg, parity_next;
  logic              last_served_reg, last_served_next;
  logic              frame_sel_reg, frame_sel_next;
  logic              gnt0_reg, gnt0_next;
  logic              gnt1_reg, gnt1_next;
  logic              ser_out_reg, ser_out_next;
  logic              ser_valid_reg, ser_valid_next;
  logic              done_reg, done_next;
  logic              busy_reg, busy_next;

  logic              any_req;
  logic              sel;
  logic [DATA_W-1:0] sel_word;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      sel = ~last_served_reg;
    end else begin
      sel = bus.req1;
    end
    sel_word = sel ? bus.data1 : bus.data0;
  end

  // Frame sequencing and the next value of every registered output.
  always_comb begin
    state_next       = state_reg;
    shreg_next       = shreg_reg;
    cnt_next         = cnt_reg;
    parity_next      = parity_reg;
    last_served_next = last_served_reg;
    frame_sel_next   = frame_sel_reg;
    gnt0_next        = 1'b0;
    gnt1_next        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next       = SHIFT;
          shreg_next       = sel_word;
          parity_next      = ^sel_word;
          frame_sel_next   = sel;
          last_served_next = sel;
          gnt0_next        = ~sel;
          gnt1_next        = sel;
          cnt_next         = '0;
        end
      end
      SHIFT: begin
        shreg_next = shreg_reg >> 1;
        cnt_next   = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(DATA_W - 1)) begin
          state_next = PARITY;
        end
      end
      PARITY: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs reflect the state being entered, so they line up with it after the edge.
    ser_valid_next = (state_next != IDLE);
    busy_next      = (state_next != IDLE);
    done_next      = (state_next == PARITY);
    if (state_next == SHIFT) begin
      ser_out_next = shreg_next[0];
    end else if (state_next == PARITY) begin
      ser_out_next = parity_next;
    end else begin
      ser_out_next = 1'b0;
    end
  end

  // State and output registers; reset aborts any frame in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      shreg_reg       <= '0;
      cnt_reg         <= '0;
      parity_reg      <= 1'b0;
      last_served_reg <= 1'b1;
      frame_sel_reg   <= 1'b0;
      gnt0_reg        <= 1'b0;
      gnt1_reg        <= 1'b0;
      ser_out_reg     <= 1'b0;
      ser_valid_reg   <= 1'b0;
      done_reg        <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shreg_reg       <= shreg_next;
      cnt_reg         <= cnt_next;
      parity_reg      <= parity_next;
      last_served_reg <= last_served_next;
      frame_sel_reg   <= frame_sel_next;
      gnt0_reg        <= gnt0_next;
      gnt1_reg        <= gnt1_next;
      ser_out_reg     <= ser_out_next;
      ser_valid_reg   <= ser_valid_next;
      done_reg        <= done_next;
      busy_reg        <= busy_next;
    end
  end

  assign bus.gnt0      = gnt0_reg;
  assign bus.gnt1      = gnt1_reg;
  assign bus.ser_out   = ser_out_reg;
  assign bus.ser_valid = ser_valid_reg;
  assign bus.frame_sel = frame_sel_reg;
  assign bus.done      = done_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_p2s_tx_arbiter.sv
// Directed bench for p2s_tx_arbiter: a 4-bit instance for arbitration, timing,
// mid-frame input changes and asynchronous reset, and an 8-bit instance for width.
module tb_p2s_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  p2s_tx_arbiter_if #(.DATA_W(4)) bus ();
  p2s_tx_arbiter_if #(.DATA_W(8)) bus8 ();

  p2s_tx_arbiter #(.DATA_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  p2s_tx_arbiter #(.DATA_W(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int errors = 0;
  int checks = 0;

  logic cap_out   [16];
  logic cap_valid [16];
  logic cap_done  [16];
  logic cap_busy  [16];
  logic cap_gnt0  [16];
  logic cap_gnt1  [16];
  logic cap_sel   [16];

  // Record n consecutive cycles of the 4-bit instance, sampled at negedges.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_out[i]   = bus.ser_out;
      cap_valid[i] = bus.ser_valid;
      cap_done[i]  = bus.done;
      cap_busy[i]  = bus.busy;
      cap_gnt0[i]  = bus.gnt0;
      cap_gnt1[i]  = bus.gnt1;
      cap_sel[i]   = bus.frame_sel;
      @(negedge clk);
    end
  endtask

  // Advance to the first negedge where the 4-bit instance shows ser_valid (bounded).
  task automatic sync_frame(output bit found);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.ser_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus8.req0 = 1'b0;
    bus8.req1 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.ser_out, bus.ser_valid, bus.frame_sel, bus.done, bus.busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {bus.gnt0, bus.gnt1, bus.ser_out, bus.ser_valid, bus.frame_sel, bus.done, bus.busy});
    end
    checks++;
    if ({bus8.gnt0, bus8.gnt1, bus8.ser_out, bus8.ser_valid, bus8.frame_sel, bus8.done, bus8.busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs_w8: got %b required 0000000",
               {bus8.gnt0, bus8.gnt1, bus8.ser_out, bus8.ser_valid, bus8.frame_sel, bus8.done, bus8.busy});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.ser_valid, bus.busy} !== 4'b0) begin
      errors++;
      $display("FAIL idle_no_req: got %b required 0000", {bus.gnt0, bus.gnt1, bus.ser_valid, bus.busy});
    end
    $display("reset released, outputs idle");
  endtask

  task automatic test_single_req0();
    bit found;
    logic [4:0] exp_bits = 5'b01100;
    bus.req1 = 1'b0;
    bus.data0 = 4'b1100;
    bus.req0 = 1'b1;
    @(negedge clk);
    sync_frame(found);
    checks++;
    if (!found) begin errors++; $display("FAIL single0_start: ser_valid got 0 required 1"); end
    bus.req0 = 1'b0;
    capture(6);
    checks++;
    if ({cap_gnt0[0], cap_gnt1[0], cap_sel[0]} !== 3'b100) begin
      errors++;
      $display("FAIL single0_grant: gnt0,gnt1,sel got %b required 100", {cap_gnt0[0], cap_gnt1[0], cap_sel[0]});
    end
    checks++;
    if (cap_gnt0[1] !== 1'b0) begin errors++; $display("FAIL single0_gnt_pulse: gnt0 second cycle got %b required 0", cap_gnt0[1]); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({cap_out[i], cap_valid[i], cap_done[i], cap_busy[i]} !== {exp_bits[i], 1'b1, (i == 4), 1'b1}) begin
        errors++;
        $display("FAIL single0_bit%0d: out,valid,done,busy got %b required %b", i,
                 {cap_out[i], cap_valid[i], cap_done[i], cap_busy[i]}, {exp_bits[i], 1'b1, (i == 4), 1'b1});
      end
    end
    checks++;
    if ({cap_valid[5], cap_busy[5], cap_done[5]} !== 3'b000) begin
      errors++;
      $display("FAIL single0_end: valid,busy,done got %b required 000", {cap_valid[5], cap_busy[5], cap_done[5]});
    end
    $display("frame single0 src=%0d bits=%b%b%b%b parity=%b", cap_sel[0], cap_out[0], cap_out[1], cap_out[2], cap_out[3], cap_out[4]);
    drain();
  endtask

  task automatic test_single_req1();
    bit found;
    logic [4:0] exp_bits = 5'b10111;
    bus.req0 = 1'b0;
    bus.data1 = 4'b0111;
    bus.req1 = 1'b1;
    @(negedge clk);
    sync_frame(found);
    checks++;
    if (!found) begin errors++; $display("FAIL single1_start: ser_valid got 0 required 1"); end
    bus.req1 = 1'b0;
    capture(6);
    checks++;
    if ({cap_gnt0[0], cap_gnt1[0], cap_sel[0]} !== 3'b011) begin
      errors++;
      $display("FAIL single1_grant: gnt0,gnt1,sel got %b required 011", {cap_gnt0[0], cap_gnt1[0], cap_sel[0]});
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({cap_out[i], cap_valid[i], cap_done[i], cap_sel[i]} !== {exp_bits[i], 1'b1, (i == 4), 1'b1}) begin
        errors++;
        $display("FAIL single1_bit%0d: out,valid,done,sel got %b required %b", i,
                 {cap_out[i], cap_valid[i], cap_done[i], cap_sel[i]}, {exp_bits[i], 1'b1, (i == 4), 1'b1});
      end
    end
    checks++;
    if ({cap_valid[5], cap_busy[5]} !== 2'b00) begin
      errors++;
      $display("FAIL single1_end: valid,busy got %b required 00", {cap_valid[5], cap_busy[5]});
    end
    $display("frame single1 src=%0d bits=%b%b%b%b parity=%b", cap_sel[0], cap_out[0], cap_out[1], cap_out[2], cap_out[3], cap_out[4]);
    drain();
  endtask

  task automatic test_back_to_back();
    int g_cyc [4];
    int g_src [4];
    int d_cyc [4];
    int ng = 0;
    int nd = 0;
    rst_n = 1'b0;
    bus.data0 = 4'b1100;
    bus.data1 = 4'b0101;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 28; c++) begin
      if ((bus.gnt0 | bus.gnt1) === 1'b1 && ng < 4) begin
        g_cyc[ng] = c;
        g_src[ng] = (bus.gnt1 === 1'b1) ? 1 : 0;
        checks++;
        if (bus.frame_sel !== 1'(ng % 2)) begin
          errors++;
          $display("FAIL b2b_sel%0d: frame_sel got %b required %0d", ng, bus.frame_sel, ng % 2);
        end
        $display("grant %0d src=%0d cycle=%0d", ng, g_src[ng], c);
        ng++;
        if (ng == 4) begin
          bus.req0 = 1'b0;
          bus.req1 = 1'b0;
        end
      end
      if (bus.done === 1'b1 && nd < 4) begin
        d_cyc[nd] = c;
        checks++;
        if (bus.ser_out !== 1'b0) begin
          errors++;
          $display("FAIL b2b_parity%0d: ser_out got %b required 0", nd, bus.ser_out);
        end
        nd++;
      end
      @(negedge clk);
    end
    checks++;
    if (ng != 4 || nd != 4) begin errors++; $display("FAIL b2b_count: grants=%0d dones=%0d required 4 and 4", ng, nd); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (g_src[k] != (k % 2)) begin errors++; $display("FAIL b2b_order%0d: src got %0d required %0d", k, g_src[k], k % 2); end
      checks++;
      if (d_cyc[k] != g_cyc[k] + 4) begin errors++; $display("FAIL b2b_done%0d: done cycle got %0d required %0d", k, d_cyc[k], g_cyc[k] + 4); end
      if (k > 0) begin
        checks++;
        if (g_cyc[k] - g_cyc[k-1] != 6) begin
          errors++;
          $display("FAIL b2b_period%0d: period got %0d required 6", k, g_cyc[k] - g_cyc[k-1]);
        end
      end
    end
    drain();
  endtask

  task automatic test_midframe_change();
    bit found;
    int extra = 0;
    logic [4:0] exp_bits = 5'b01100;
    logic [4:0] got_bits = '0;
    logic [4:0] got_done = '0;
    bus.req1 = 1'b0;
    bus.data0 = 4'b1100;
    bus.req0 = 1'b1;
    @(negedge clk);
    sync_frame(found);
    checks++;
    if (!found) begin errors++; $display("FAIL mid_start: ser_valid got 0 required 1"); end
    for (int i = 0; i < 5; i++) begin
      got_bits[i] = bus.ser_out;
      got_done[i] = bus.done;
      if (i == 0) bus.data0 = 4'b1111;
      if (i == 2) bus.req0 = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (got_bits !== exp_bits) begin errors++; $display("FAIL mid_bits: parity..bit0 got %b required %b", got_bits, exp_bits); end
    checks++;
    if (got_done !== 5'b10000) begin errors++; $display("FAIL mid_done: done trace got %b required 10000", got_done); end
    for (int i = 0; i < 10; i++) begin
      if ((bus.gnt0 | bus.gnt1 | bus.ser_valid) === 1'b1) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL mid_no_regrant: active cycles got %0d required 0", extra); end
    $display("frame midchange bits(parity..bit0)=%b extra=%0d", got_bits, extra);
    drain();
  endtask

  task automatic test_async_reset();
    bit found;
    int seen_done = 0;
    logic [4:0] exp_bits = 5'b10111;
    bus.req1 = 1'b0;
    bus.data0 = 4'b1100;
    bus.req0 = 1'b1;
    @(negedge clk);
    sync_frame(found);
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ser_valid !== 1'b1) begin errors++; $display("FAIL arst_inframe: ser_valid got %b required 1", bus.ser_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.ser_out, bus.ser_valid, bus.frame_sel, bus.done, bus.busy} !== 7'b0) begin
      errors++;
      $display("FAIL arst_immediate: got %b required 0000000",
               {bus.gnt0, bus.gnt1, bus.ser_out, bus.ser_valid, bus.frame_sel, bus.done, bus.busy});
    end
    bus.data1 = 4'b0111;
    bus.req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ((bus.done | bus.ser_valid) !== 1'b0) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin errors++; $display("FAIL arst_held: active cycles got %0d required 0", seen_done); end
    rst_n = 1'b1;
    sync_frame(found);
    checks++;
    if (!found) begin errors++; $display("FAIL arst_restart: ser_valid got 0 required 1"); end
    bus.req1 = 1'b0;
    capture(6);
    checks++;
    if ({cap_gnt0[0], cap_gnt1[0], cap_sel[0]} !== 3'b011) begin
      errors++;
      $display("FAIL arst_grant: gnt0,gnt1,sel got %b required 011", {cap_gnt0[0], cap_gnt1[0], cap_sel[0]});
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({cap_out[i], cap_valid[i], cap_done[i]} !== {exp_bits[i], 1'b1, (i == 4)}) begin
        errors++;
        $display("FAIL arst_bit%0d: out,valid,done got %b required %b", i,
                 {cap_out[i], cap_valid[i], cap_done[i]}, {exp_bits[i], 1'b1, (i == 4)});
      end
    end
    checks++;
    if (cap_valid[5] !== 1'b0) begin errors++; $display("FAIL arst_end: ser_valid got %b required 0", cap_valid[5]); end
    $display("frame after_reset src=%0d bits=%b%b%b%b parity=%b", cap_sel[0], cap_out[0], cap_out[1], cap_out[2], cap_out[3], cap_out[4]);
    drain();
  endtask

  task automatic test_width8();
    bit found = 1'b0;
    logic [8:0] exp_bits = 9'b0_1010_0101;
    logic [8:0] got_bits = '0;
    logic [8:0] got_valid = '0;
    logic [8:0] got_done = '0;
    logic g0 = 1'b0;
    logic sel = 1'b1;
    bus8.req1 = 1'b0;
    bus8.data0 = 8'hA5;
    bus8.req0 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (bus8.ser_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL w8_start: ser_valid got 0 required 1"); end
    g0 = bus8.gnt0;
    sel = bus8.frame_sel;
    bus8.req0 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      got_bits[i] = bus8.ser_out;
      got_valid[i] = bus8.ser_valid;
      got_done[i] = bus8.done;
      @(negedge clk);
    end
    checks++;
    if ({g0, sel} !== 2'b10) begin errors++; $display("FAIL w8_grant: gnt0,sel got %b required 10", {g0, sel}); end
    checks++;
    if (got_bits !== exp_bits) begin errors++; $display("FAIL w8_bits: parity..bit0 got %b required %b", got_bits, exp_bits); end
    checks++;
    if (got_valid !== 9'h1FF) begin errors++; $display("FAIL w8_valid: valid trace got %b required 111111111", got_valid); end
    checks++;
    if (got_done !== 9'b1_0000_0000) begin errors++; $display("FAIL w8_done: done trace got %b required 100000000", got_done); end
    checks++;
    if ({bus8.ser_valid, bus8.busy} !== 2'b00) begin
      errors++;
      $display("FAIL w8_end: valid,busy got %b required 00", {bus8.ser_valid, bus8.busy});
    end
    $display("frame width8 bits(parity..bit0)=%b", got_bits);
    drain();
  endtask

  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;
    bus8.req0 = 1'b0;
    bus8.req1 = 1'b0;
    bus8.data0 = '0;
    bus8.data1 = '0;
    rst_n = 1'b0;
    test_reset();
    test_single_req0();
    test_single_req1();
    test_back_to_back();
    test_midframe_change();
    test_async_reset();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
